// File: rtl/sum_sequencer.sv
// Sequencing controller for the switch-operand adder: enter A, enter B,
// add, show; the shown result can be chained back in as operand A.
module sum_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_next,
    input  logic             btn_acc,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             overload,
    output logic             result_valid,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CALC    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] switch_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] res_d;
    logic             ov_d;
    logic             rv_d;
    logic             done_d;
    logic [WIDTH:0]   sum;

    // Full-width sum so the carry lands in overload
    assign sum   = {1'b0, operand_a} + {1'b0, operand_b};
    assign state = state_q;

    // Next-state and next-output logic; everything holds unless a state acts
    always_comb begin
        state_d = state_q;
        a_d     = operand_a;
        b_d     = operand_b;
        res_d   = result;
        ov_d    = overload;
        rv_d    = result_valid;
        done_d  = 1'b0;
        unique case (state_q)
            ENTER_A: begin
                a_d = switch_q;
                if (btn_next) state_d = ENTER_B;
            end
            ENTER_B: begin
                b_d = switch_q;
                if (btn_next) state_d = CALC;
            end
            CALC: begin
                {ov_d, res_d} = sum;
                rv_d    = 1'b1;
                done_d  = 1'b1;
                state_d = SHOW;
            end
            SHOW: begin
                if (btn_acc) begin
                    a_d     = result;
                    res_d   = '0;
                    ov_d    = 1'b0;
                    rv_d    = 1'b0;
                    state_d = ENTER_B;
                end else if (btn_next) begin
                    res_d   = '0;
                    ov_d    = 1'b0;
                    rv_d    = 1'b0;
                    state_d = ENTER_A;
                end
            end
        endcase
    end

    // State, switch sample and all outputs registered; reset wins
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ENTER_A;
            switch_q     <= '0;
            operand_a    <= '0;
            operand_b    <= '0;
            result       <= '0;
            overload     <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            switch_q     <= switch;
            operand_a    <= a_d;
            operand_b    <= b_d;
            result       <= res_d;
            overload     <= ov_d;
            result_valid <= rv_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_sum_sequencer.sv
// Directed bench for sum_sequencer: per-cycle vector table plus
// hand-written reset, reset-in-CALC and overflow sequences.
module tb_sum_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_next;
    logic       btn_acc;
    logic [7:0] switch;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [7:0] result;
    logic       overload;
    logic       result_valid;
    logic       done;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    sum_sequencer #(.WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_next     (btn_next),
        .btn_acc      (btn_acc),
        .switch       (switch),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .result       (result),
        .overload     (overload),
        .result_valid (result_valid),
        .done         (done),
        .state        (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] sw;
        logic       nx;
        logic       ac;
        logic [1:0] st;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ov;
        logic       rv;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string p, input logic [1:0] st,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] res, input logic ov,
                             input logic rv, input logic dn);
        check({p, ".state"}, 32'(state), 32'(st));
        check({p, ".a"}, 32'(operand_a), 32'(a));
        check({p, ".b"}, 32'(operand_b), 32'(b));
        check({p, ".res"}, 32'(result), 32'(res));
        check({p, ".ov"}, 32'(overload), 32'(ov));
        check({p, ".rv"}, 32'(result_valid), 32'(rv));
        check({p, ".done"}, 32'(done), 32'(dn));
    endtask

    initial begin
        int cyc;
        int ndone;

        // sw nx ac | st a b res ov rv dn  (outputs after the edge)
        // 0x7F + 0x01
        tbl.push_back('{8'h7F,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h7F,1'b0,1'b0,2'd0,8'h7F,8'h00,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h7F,1'b1,1'b0,2'd1,8'h7F,8'h00,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h01,1'b0,1'b0,2'd1,8'h7F,8'h7F,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h01,1'b0,1'b0,2'd1,8'h7F,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h01,1'b1,1'b0,2'd2,8'h7F,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h01,1'b0,1'b0,2'd3,8'h7F,8'h01,8'h80,1'b0,1'b1,1'b1});
        tbl.push_back('{8'h01,1'b0,1'b0,2'd3,8'h7F,8'h01,8'h80,1'b0,1'b1,1'b0});
        tbl.push_back('{8'h01,1'b1,1'b0,2'd0,8'h7F,8'h01,8'h00,1'b0,1'b0,1'b0});
        // 0xFF + 0x01 wraps
        tbl.push_back('{8'hFF,1'b0,1'b0,2'd0,8'h01,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'hFF,1'b0,1'b0,2'd0,8'hFF,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'hFF,1'b1,1'b0,2'd1,8'hFF,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h01,1'b0,1'b0,2'd1,8'hFF,8'hFF,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h01,1'b1,1'b0,2'd2,8'hFF,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h01,1'b0,1'b0,2'd3,8'hFF,8'h01,8'h00,1'b1,1'b1,1'b1});
        tbl.push_back('{8'h01,1'b1,1'b0,2'd0,8'hFF,8'h01,8'h00,1'b0,1'b0,1'b0});
        // chain 0x10 + 0x20, then + 0x05
        tbl.push_back('{8'h10,1'b0,1'b0,2'd0,8'h01,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h10,1'b0,1'b0,2'd0,8'h10,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h10,1'b1,1'b0,2'd1,8'h10,8'h01,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h20,1'b0,1'b0,2'd1,8'h10,8'h10,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h20,1'b1,1'b0,2'd2,8'h10,8'h20,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h20,1'b0,1'b0,2'd3,8'h10,8'h20,8'h30,1'b0,1'b1,1'b1});
        tbl.push_back('{8'h05,1'b0,1'b1,2'd1,8'h30,8'h20,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h05,1'b0,1'b0,2'd1,8'h30,8'h05,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h05,1'b1,1'b0,2'd2,8'h30,8'h05,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h05,1'b0,1'b0,2'd3,8'h30,8'h05,8'h35,1'b0,1'b1,1'b1});
        // next+acc together in SHOW: acc wins
        tbl.push_back('{8'h05,1'b1,1'b1,2'd1,8'h35,8'h05,8'h00,1'b0,1'b0,1'b0});
        // acc in ENTER_B ignored
        tbl.push_back('{8'h05,1'b0,1'b1,2'd1,8'h35,8'h05,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h05,1'b1,1'b0,2'd2,8'h35,8'h05,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h05,1'b0,1'b0,2'd3,8'h35,8'h05,8'h3A,1'b0,1'b1,1'b1});
        tbl.push_back('{8'h05,1'b1,1'b0,2'd0,8'h35,8'h05,8'h00,1'b0,1'b0,1'b0});
        // acc in ENTER_A ignored
        tbl.push_back('{8'h05,1'b0,1'b1,2'd0,8'h05,8'h05,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h05,1'b0,1'b0,2'd0,8'h05,8'h05,8'h00,1'b0,1'b0,1'b0});
        // next during CALC ignored
        tbl.push_back('{8'h05,1'b1,1'b0,2'd1,8'h05,8'h05,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h05,1'b1,1'b0,2'd2,8'h05,8'h05,8'h00,1'b0,1'b0,1'b0});
        tbl.push_back('{8'h05,1'b1,1'b0,2'd3,8'h05,8'h05,8'h0A,1'b0,1'b1,1'b1});
        tbl.push_back('{8'h05,1'b0,1'b0,2'd3,8'h05,8'h05,8'h0A,1'b0,1'b1,1'b0});
        tbl.push_back('{8'h05,1'b0,1'b0,2'd3,8'h05,8'h05,8'h0A,1'b0,1'b1,1'b0});

        reset    = 1'b1;
        btn_next = 1'b0;
        btn_acc  = 1'b0;
        switch   = 8'h00;
        step(2);
        check_all("reset", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            switch   = tbl[i].sw;
            btn_next = tbl[i].nx;
            btn_acc  = tbl[i].ac;
            step(1);
            check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].a, tbl[i].b,
                      tbl[i].res, tbl[i].ov, tbl[i].rv, tbl[i].dn);
        end

        // reset while in ENTER_B with operand_a = 0x42
        btn_acc  = 1'b0;
        btn_next = 1'b1;
        switch   = 8'h42;
        step(1);
        check("rst6.leave_show", 32'(state), 32'd0);
        btn_next = 1'b0;
        step(1);
        check("rst6.a_track", 32'(operand_a), 32'h42);
        btn_next = 1'b1;
        step(1);
        check("rst6.in_b", 32'(state), 32'd1);
        check("rst6.a42", 32'(operand_a), 32'h42);
        btn_next = 1'b0;
        reset    = 1'b1;
        step(1);
        check_all("rst6.after", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        reset  = 1'b0;
        switch = 8'h33;
        step(2);
        check("rst6.retrack", 32'(operand_a), 32'h33);
        check("rst6.state", 32'(state), 32'd0);

        // reset asserted while in CALC
        btn_next = 1'b1;
        step(1);
        btn_next = 1'b0;
        step(1);
        btn_next = 1'b1;
        step(1);
        check("rcalc.in_calc", 32'(state), 32'd2);
        btn_next = 1'b0;
        reset    = 1'b1;
        step(1);
        check_all("rcalc.after", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // 0xC8 + 0x64 = 0x12C, bounded wait for the result
        switch = 8'hC8;
        step(2);
        btn_next = 1'b1;
        step(1);
        btn_next = 1'b0;
        switch   = 8'h64;
        step(2);
        btn_next = 1'b1;
        step(1);
        btn_next = 1'b0;
        cyc   = 0;
        ndone = 0;
        while (!result_valid && cyc < 6) begin
            step(1);
            cyc++;
            if (done) ndone++;
        end
        check("ovf.valid", 32'(result_valid), 32'd1);
        check("ovf.latency", 32'(cyc), 32'd1);
        check("ovf.res", 32'(result), 32'h2C);
        check("ovf.ov", 32'(overload), 32'd1);
        repeat (3) begin
            step(1);
            if (done) ndone++;
        end
        check("ovf.done_once", 32'(ndone), 32'd1);
        check("ovf.hold", 32'(state), 32'd3);

        // chain after overflow: carry dropped, truncated result becomes A
        btn_acc = 1'b1;
        step(1);
        btn_acc = 1'b0;
        check("ovf.chain_a", 32'(operand_a), 32'h2C);
        check("ovf.chain_ov", 32'(overload), 32'd0);
        check("ovf.chain_st", 32'(state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
